// File: rtl/f2i_if.sv
// Operand/result bundle for the bfloat16-to-fixed converter.
// The master side drives the operand strobe; the slave side returns the fixed-point result and status.
interface f2i_if #(
  parameter int EXP_WIDTH   = 8,
  parameter int FRACT_WIDTH = 7
);
  logic                   valid_i;
  logic                   sgn_i;
  logic [EXP_WIDTH-1:0]   exp_i;
  logic [FRACT_WIDTH-1:0] fract_i;
  logic [EXP_WIDTH-1:0]   integer_o;
  logic [FRACT_WIDTH-1:0] fract_o;
  logic                   valid_o;
  logic                   busy_o;
  logic                   ovf_o;
  logic                   unf_o;
  logic                   nan_o;

  modport master (
    output valid_i, sgn_i, exp_i, fract_i,
    input  integer_o, fract_o, valid_o, busy_o, ovf_o, unf_o, nan_o
  );

  modport slave (
    input  valid_i, sgn_i, exp_i, fract_i,
    output integer_o, fract_o, valid_o, busy_o, ovf_o, unf_o, nan_o
  );
endinterface

// File: rtl/f2i.sv
// Iterative bfloat16 to signed fixed-point converter: one denormalising shift per clock,
// round-half-up on magnitude, saturation with ovf/unf/nan status.
module f2i #(
  parameter int EXP_WIDTH   = 8,
  parameter int FRACT_WIDTH = 7,
  parameter int BIAS        = 127
) (
  input  logic clk,
  input  logic rst,
  f2i_if.slave bus
);
  localparam int W  = EXP_WIDTH + FRACT_WIDTH;
  localparam int EW = EXP_WIDTH + 2;
  localparam int CW = 4;
  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_SAT  = EW'(FRACT_WIDTH);
  localparam logic signed [EW-1:0] E_UNF  = EW'(-(FRACT_WIDTH + 2));
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, ROUND} state_t;

  state_t                 state_reg, state_next;
  logic                   sgn_reg, sgn_next;
  logic [EXP_WIDTH-1:0]   exp_reg, exp_next;
  logic [FRACT_WIDTH-1:0] fract_reg, fract_next;
  logic [W-1:0]           mag_reg, mag_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   dir_reg, dir_next;
  logic                   rnd_reg, rnd_next;
  logic                   ovf_reg, ovf_next;
  logic                   unf_reg, unf_next;
  logic                   nan_reg, nan_next;
  logic [EXP_WIDTH-1:0]   int_out_reg, int_out_next;
  logic [FRACT_WIDTH-1:0] fract_out_reg, fract_out_next;
  logic                   valid_out_reg, valid_out_next;
  logic                   ovf_out_reg, ovf_out_next;
  logic                   unf_out_reg, unf_out_next;
  logic                   nan_out_reg, nan_out_next;

  logic signed [EW-1:0]   e_val;
  logic [FRACT_WIDTH:0]   mant;
  logic [W-1:0]           mag_rnd;
  logic [W-1:0]           res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      sgn_reg       <= 1'b0;
      exp_reg       <= '0;
      fract_reg     <= '0;
      mag_reg       <= '0;
      cnt_reg       <= '0;
      dir_reg       <= 1'b0;
      rnd_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
      nan_reg       <= 1'b0;
      int_out_reg   <= '0;
      fract_out_reg <= '0;
      valid_out_reg <= 1'b0;
      ovf_out_reg   <= 1'b0;
      unf_out_reg   <= 1'b0;
      nan_out_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sgn_reg       <= sgn_next;
      exp_reg       <= exp_next;
      fract_reg     <= fract_next;
      mag_reg       <= mag_next;
      cnt_reg       <= cnt_next;
      dir_reg       <= dir_next;
      rnd_reg       <= rnd_next;
      ovf_reg       <= ovf_next;
      unf_reg       <= unf_next;
      nan_reg       <= nan_next;
      int_out_reg   <= int_out_next;
      fract_out_reg <= fract_out_next;
      valid_out_reg <= valid_out_next;
      ovf_out_reg   <= ovf_out_next;
      unf_out_reg   <= unf_out_next;
      nan_out_reg   <= nan_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sgn_next       = sgn_reg;
    exp_next       = exp_reg;
    fract_next     = fract_reg;
    mag_next       = mag_reg;
    cnt_next       = cnt_reg;
    dir_next       = dir_reg;
    rnd_next       = rnd_reg;
    ovf_next       = ovf_reg;
    unf_next       = unf_reg;
    nan_next       = nan_reg;
    int_out_next   = int_out_reg;
    fract_out_next = fract_out_reg;
    valid_out_next = 1'b0;
    ovf_out_next   = ovf_out_reg;
    unf_out_next   = unf_out_reg;
    nan_out_next   = nan_out_reg;

    e_val   = $signed({2'b00, exp_reg}) - E_BIAS;
    mant    = {1'b1, fract_reg};
    mag_rnd = mag_reg + W'(rnd_reg);
    res     = sgn_reg ? -mag_rnd : mag_rnd;

    case (state_reg)
      IDLE: begin
        if (bus.valid_i) begin
          sgn_next     = bus.sgn_i;
          exp_next     = bus.exp_i;
          fract_next   = bus.fract_i;
          ovf_next     = 1'b0;
          unf_next     = 1'b0;
          nan_next     = 1'b0;
          ovf_out_next = 1'b0;
          unf_out_next = 1'b0;
          nan_out_next = 1'b0;
          state_next   = CHECK;
        end
      end

      CHECK: begin
        // Special cases preload the final magnitude so ROUND treats every path alike.
        rnd_next   = 1'b0;
        state_next = ROUND;
        if (exp_reg == '0) begin
          mag_next = '0;
          unf_next = (fract_reg != '0);
        end else if (&exp_reg) begin
          ovf_next = 1'b1;
          if (fract_reg != '0) begin
            nan_next = 1'b1;
            sgn_next = 1'b0;
            mag_next = MAX_POS;
          end else begin
            mag_next = sgn_reg ? MAX_NEG : MAX_POS;
          end
        end else if (e_val >= E_SAT) begin
          if (sgn_reg && (e_val == E_SAT) && (fract_reg == '0)) begin
            mag_next = MAX_NEG;
          end else begin
            ovf_next = 1'b1;
            mag_next = sgn_reg ? MAX_NEG : MAX_POS;
          end
        end else if (e_val <= E_UNF) begin
          mag_next = '0;
          unf_next = 1'b1;
        end else begin
          mag_next = W'(mant);
          dir_next = e_val[EW-1];
          cnt_next = e_val[EW-1] ? CW'(-e_val) : CW'(e_val);
          if (e_val != '0) begin
            state_next = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (dir_reg) begin
          mag_next = mag_reg >> 1;
          rnd_next = mag_reg[0];
        end else begin
          mag_next = mag_reg << 1;
        end
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next = ROUND;
        end
      end

      ROUND: begin
        int_out_next   = res[W-1:FRACT_WIDTH];
        fract_out_next = res[FRACT_WIDTH-1:0];
        ovf_out_next   = ovf_reg;
        unf_out_next   = unf_reg;
        nan_out_next   = nan_reg;
        valid_out_next = 1'b1;
        state_next     = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.integer_o = int_out_reg;
  assign bus.fract_o   = fract_out_reg;
  assign bus.valid_o   = valid_out_reg;
  assign bus.busy_o    = (state_reg != IDLE);
  assign bus.ovf_o     = ovf_out_reg;
  assign bus.unf_o     = unf_out_reg;
  assign bus.nan_o     = nan_out_reg;
endmodule
